gantry_motion_ctrl: RTL and testbench

//  Consumes the decoder's one-cycle command pulses and drives the X/Y stepper gantry and electromagnet.

---
 rtl/gantry_motion_ctrl_pkg.sv | 41 ++++
 rtl/gantry_motion_ctrl_if.sv | 29 ++
 rtl/gantry_motion_ctrl_step_pulse_gen.sv | 38 +++
 rtl/gantry_motion_ctrl.sv | 179 +++++++++++++++++
 tb/tb_gantry_motion_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/gantry_motion_ctrl_pkg.sv
// Shared types and constants for the gantry motion controller.
// Direction bit positions follow the decoder's compass ordering, clockwise from north.
package gantry_motion_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_HOME_X,
    ST_HOME_Y,
    ST_DONE
  } state_e;

  localparam int DIR_N  = 0;
  localparam int DIR_NE = 1;
  localparam int DIR_E  = 2;
  localparam int DIR_SE = 3;
  localparam int DIR_S  = 4;
  localparam int DIR_SW = 5;
  localparam int DIR_W  = 6;
  localparam int DIR_NW = 7;

  localparam logic AXIS_POS = 1'b1;
  localparam logic AXIS_NEG = 1'b0;

  localparam logic [7:0] POS_X_MASK = (8'h01 << DIR_NE) | (8'h01 << DIR_E) | (8'h01 << DIR_SE);
  localparam logic [7:0] NEG_X_MASK = (8'h01 << DIR_SW) | (8'h01 << DIR_W) | (8'h01 << DIR_NW);
  localparam logic [7:0] POS_Y_MASK = (8'h01 << DIR_N)  | (8'h01 << DIR_NE) | (8'h01 << DIR_NW);
  localparam logic [7:0] NEG_Y_MASK = (8'h01 << DIR_SE) | (8'h01 << DIR_S)  | (8'h01 << DIR_SW);

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gantry_motion_ctrl_if.sv
// Command pulses, limit switches and actuator/status outputs of the gantry controller.
interface gantry_motion_ctrl_if;
  logic [7:0] direction;
  logic       reset;
  logic       horizontal_offset;
  logic       magnet_on;
  logic       magnet_off;
  logic       limit_x_n;
  logic       limit_y_n;
  logic       step_x;
  logic       step_y;
  logic       dir_x;
  logic       dir_y;
  logic       magnet;
  logic       busy;
  logic       move_done;
  logic       cmd_dropped;
  logic       fault;

  modport master (
    output direction, reset, horizontal_offset, magnet_on, magnet_off, limit_x_n, limit_y_n,
    input  step_x, step_y, dir_x, dir_y, magnet, busy, move_done, cmd_dropped, fault
  );

  modport slave (
    input  direction, reset, horizontal_offset, magnet_on, magnet_off, limit_x_n, limit_y_n,
    output step_x, step_y, dir_x, dir_y, magnet, busy, move_done, cmd_dropped, fault
  );
endinterface

// File: rtl/gantry_motion_ctrl_step_pulse_gen.sv
// Step period counter: step level for the first PULSE_W cycles of each period,
// plus markers for the first and last cycle of the period.
module step_pulse_gen #(
  parameter int STEP_PERIOD = 50000,
  parameter int PULSE_W     = 500,
  parameter int CW          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic step_lvl,
  output logic period_tick,
  output logic period_start
);

  localparam logic [CW-1:0] LAST = CW'(STEP_PERIOD - 1);
  localparam logic [CW-1:0] PW   = CW'(PULSE_W);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run && !clear) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign step_lvl     = run && (cnt_q < PW);
  assign period_tick  = run && (cnt_q == LAST);
  assign period_start = run && (cnt_q == '0);

endmodule

// File: rtl/gantry_motion_ctrl.sv
// X/Y stepper gantry sequencer: one-square compass moves, half-square offset,
// limit-switch homing with timeout, and the electromagnet latch.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a motion command
//   ST_MOVE   | stepping latched axes/directions until target steps done
//   ST_HOME_X | stepping X- until hit_x or HOME_MAX steps
//   ST_HOME_Y | stepping Y- until hit_y or HOME_MAX steps
//   ST_DONE   | single cycle, move_done high
module gantry_motion_ctrl
  import gantry_motion_ctrl_pkg::*;
#(
  parameter int SQUARE_STEPS = 400,
  parameter int OFFSET_STEPS = 200,
  parameter int STEP_PERIOD  = 50000,
  parameter int PULSE_W      = 500,
  parameter int HOME_MAX     = 4000
) (
  input logic                 clk,
  input logic                 rst_n,
  gantry_motion_ctrl_if.slave bus
);

  localparam int CW = cnt_width(STEP_PERIOD, HOME_MAX, SQUARE_STEPS);
  localparam logic [CW-1:0] SQ_C  = CW'(SQUARE_STEPS);
  localparam logic [CW-1:0] OFF_C = CW'(OFFSET_STEPS);
  localparam logic [CW-1:0] HM_C  = CW'(HOME_MAX);

  state_e        state_q, state_d;
  logic [CW-1:0] steps_q, steps_d, target_q, target_d, steps_inc;
  logic          en_x_q, en_x_d, en_y_q, en_y_d, dx_q, dx_d, dy_q, dy_d;
  logic          fault_q, fault_d, drop_q, drop_d, magnet_q, magnet_d;
  logic [1:0]    sync_x_q, sync_y_q;
  logic          hit_x, hit_y, valid_dir, motion_cmd, clear, run;
  logic          step_lvl, period_tick, period_start, stop_x, stop_y;

  assign hit_x = ~sync_x_q[1];
  assign hit_y = ~sync_y_q[1];
  assign run   = (state_q == ST_MOVE) || (state_q == ST_HOME_X) || (state_q == ST_HOME_Y);

  step_pulse_gen #(
    .STEP_PERIOD(STEP_PERIOD),
    .PULSE_W    (PULSE_W),
    .CW         (CW)
  ) u_step (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .run         (run),
    .step_lvl    (step_lvl),
    .period_tick (period_tick),
    .period_start(period_start)
  );

  // Homing decisions are made only on the first cycle of each period, so a
  // switch closing mid-pulse never truncates the pulse already in flight.
  assign stop_x = period_start && (hit_x || (steps_q == HM_C));
  assign stop_y = period_start && (hit_y || (steps_q == HM_C));

  always_comb begin
    state_d    = state_q;
    steps_d    = steps_q;
    target_d   = target_q;
    en_x_d     = en_x_q;
    en_y_d     = en_y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    fault_d    = fault_q;
    clear      = 1'b0;
    valid_dir  = is_onehot8(bus.direction);
    motion_cmd = bus.reset || valid_dir || bus.horizontal_offset;
    steps_inc  = steps_q + 1'b1;
    drop_d     = (state_q != ST_IDLE) && motion_cmd;
    magnet_d   = bus.magnet_off ? 1'b0 : (bus.magnet_on ? 1'b1 : magnet_q);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.reset) begin
          state_d = ST_HOME_X;
          steps_d = '0;
          fault_d = 1'b0;
          clear   = 1'b1;
        end else if (valid_dir) begin
          state_d  = ST_MOVE;
          steps_d  = '0;
          target_d = SQ_C;
          en_x_d   = |(bus.direction & (POS_X_MASK | NEG_X_MASK));
          en_y_d   = |(bus.direction & (POS_Y_MASK | NEG_Y_MASK));
          dx_d     = |(bus.direction & POS_X_MASK) ? AXIS_POS : AXIS_NEG;
          dy_d     = |(bus.direction & POS_Y_MASK) ? AXIS_POS : AXIS_NEG;
          clear    = 1'b1;
        end else if (bus.horizontal_offset) begin
          state_d  = ST_MOVE;
          steps_d  = '0;
          target_d = OFF_C;
          en_x_d   = 1'b1;
          en_y_d   = 1'b0;
          dx_d     = AXIS_POS;
          dy_d     = AXIS_NEG;
          clear    = 1'b1;
        end
      end
      ST_MOVE: begin
        if (period_tick) begin
          steps_d = steps_inc;
          if (steps_inc == target_q) state_d = ST_DONE;
        end
      end
      ST_HOME_X: begin
        if (period_start && hit_x) begin
          state_d = ST_HOME_Y;
          steps_d = '0;
          clear   = 1'b1;
        end else if (stop_x) begin
          fault_d = 1'b1;
          state_d = ST_DONE;
        end else if (period_tick) begin
          steps_d = steps_inc;
        end
      end
      ST_HOME_Y: begin
        if (period_start && hit_y) begin
          state_d = ST_DONE;
        end else if (stop_y) begin
          fault_d = 1'b1;
          state_d = ST_DONE;
        end else if (period_tick) begin
          steps_d = steps_inc;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      steps_q  <= '0;
      target_q <= '0;
      en_x_q   <= 1'b0;
      en_y_q   <= 1'b0;
      dx_q     <= 1'b0;
      dy_q     <= 1'b0;
      fault_q  <= 1'b0;
      drop_q   <= 1'b0;
      magnet_q <= 1'b0;
      sync_x_q <= 2'b11;
      sync_y_q <= 2'b11;
    end else begin
      state_q  <= state_d;
      steps_q  <= steps_d;
      target_q <= target_d;
      en_x_q   <= en_x_d;
      en_y_q   <= en_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      fault_q  <= fault_d;
      drop_q   <= drop_d;
      magnet_q <= magnet_d;
      sync_x_q <= {sync_x_q[0], bus.limit_x_n};
      sync_y_q <= {sync_y_q[0], bus.limit_y_n};
    end
  end

  assign bus.step_x      = step_lvl && (((state_q == ST_MOVE) && en_x_q) ||
                                        ((state_q == ST_HOME_X) && !stop_x));
  assign bus.step_y      = step_lvl && (((state_q == ST_MOVE) && en_y_q) ||
                                        ((state_q == ST_HOME_Y) && !stop_y));
  assign bus.dir_x       = (state_q == ST_MOVE) && dx_q;
  assign bus.dir_y       = (state_q == ST_MOVE) && dy_q;
  assign bus.magnet      = magnet_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.move_done   = (state_q == ST_DONE);
  assign bus.cmd_dropped = drop_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_gantry_motion_ctrl.sv
// Randomised bench for gantry_motion_ctrl against a transaction-level model
// (expected step counts, directions, durations, fault and magnet state per command).
module tb_gantry_motion_ctrl;

  localparam int SQ  = 4;
  localparam int OFF = 2;
  localparam int P   = 10;
  localparam int PW  = 3;
  localparam int HM  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gantry_motion_ctrl_if bus();

  gantry_motion_ctrl #(
    .SQUARE_STEPS(SQ),
    .OFFSET_STEPS(OFF),
    .STEP_PERIOD (P),
    .PULSE_W     (PW),
    .HOME_MAX    (HM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // compass unit vectors, bit index 0 = N, clockwise
  int xs[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int ys[8] = '{1, 1, 0, -1, -1, -1, 0, 1};

  logic mag_m   = 1'b0;
  logic fault_m = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic clear_cmds();
    bus.direction         = 8'h00;
    bus.reset             = 1'b0;
    bus.horizontal_offset = 1'b0;
  endtask

  // lim_x/lim_y: -1 switch never closes, 0 closed from the start,
  // n>0 closes after the n-th step pulse on that axis.
  task automatic exec(input logic [7:0] dir, input logic rc, input logic oc,
                      input int lim_x, input int lim_y, input bit want_drop,
                      input string tag);
    int kind, k, tgt, sx, sy, hx, hy, exp_nx, exp_ny, exp_cyc, bound, drop_at;
    int exp_dx, exp_dy, nx, ny, wx, wy, bad_w, noncoinc, dir_err, ndrop, done_cyc;
    logic psx, psy, exp_fault, saw_busy, busy_first, diag;
    k = 0;
    for (int i = 0; i < 8; i++) if (dir[i]) k = i;
    exp_nx = 0; exp_ny = 0; exp_dx = 0; exp_dy = 0; exp_cyc = 0;
    exp_fault = fault_m; diag = 1'b0;
    if (rc) begin
      kind = 2;
      hx = (lim_x < 0) ? HM : ((lim_x < HM) ? lim_x : HM);
      exp_fault = (lim_x < 0);
      hy = exp_fault ? 0 : ((lim_y < 0) ? HM : ((lim_y < HM) ? lim_y : HM));
      if (!exp_fault && lim_y < 0) exp_fault = 1'b1;
      exp_nx = hx; exp_ny = hy;
    end else if ($countones(dir) == 1 || oc) begin
      kind = 1;
      if ($countones(dir) == 1) begin tgt = SQ;  sx = xs[k]; sy = ys[k]; end
      else                      begin tgt = OFF; sx = 1;     sy = 0;     end
      exp_nx  = (sx != 0) ? tgt : 0;
      exp_ny  = (sy != 0) ? tgt : 0;
      exp_dx  = (sx > 0) ? 1 : 0;
      exp_dy  = (sy > 0) ? 1 : 0;
      exp_cyc = tgt * P + 1;
      diag    = (sx != 0) && (sy != 0);
    end else begin
      kind = 0;
    end
    bound   = (kind == 0) ? 20 : 400;
    drop_at = (want_drop && kind == 1) ? $urandom_range(2, exp_cyc - 3) : 0;

    @(negedge clk);
    bus.limit_x_n = (lim_x == 0) ? 1'b0 : 1'b1;
    bus.limit_y_n = (lim_y == 0) ? 1'b0 : 1'b1;
    repeat (3) @(negedge clk);
    bus.direction = dir; bus.reset = rc; bus.horizontal_offset = oc;

    nx = 0; ny = 0; wx = 0; wy = 0; bad_w = 0; noncoinc = 0; dir_err = 0; ndrop = 0;
    done_cyc = -1; psx = 1'b0; psy = 1'b0; saw_busy = 1'b0; busy_first = 1'b0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (i == 1) clear_cmds();
      if (drop_at > 0 && i == drop_at) begin
        case ($urandom_range(0, 2))
          0:       bus.direction = 8'h01 << $urandom_range(0, 7);
          1:       bus.reset = 1'b1;
          default: bus.horizontal_offset = 1'b1;
        endcase
      end
      if (drop_at > 0 && i == drop_at + 1) clear_cmds();
      if (i == 1) busy_first = bus.busy;
      if (bus.busy) saw_busy = 1'b1;
      if (bus.cmd_dropped) ndrop++;
      if (bus.step_x && !psx) nx++;
      if (bus.step_y && !psy) ny++;
      if (bus.step_x) wx++; else begin if (wx != 0 && wx != PW) bad_w++; wx = 0; end
      if (bus.step_y) wy++; else begin if (wy != 0 && wy != PW) bad_w++; wy = 0; end
      if (diag && bus.step_x != bus.step_y) noncoinc++;
      if (kind == 1 && bus.busy && !bus.move_done &&
          (int'(bus.dir_x) != exp_dx || int'(bus.dir_y) != exp_dy)) dir_err++;
      if (kind == 2 && (bus.dir_x || bus.dir_y)) dir_err++;
      psx = bus.step_x; psy = bus.step_y;
      if (lim_x > 0 && nx >= lim_x && !bus.step_x) bus.limit_x_n = 1'b0;
      if (lim_y > 0 && ny >= lim_y && !bus.step_y) bus.limit_y_n = 1'b0;
      if (bus.move_done) begin done_cyc = i; break; end
    end
    @(negedge clk);
    check({tag, ".after_done"}, int'({bus.move_done, bus.busy}), 0);
    fault_m = exp_fault;
    if (kind == 0) begin
      check({tag, ".no_busy"}, int'(saw_busy), 0);
      check({tag, ".no_done"}, done_cyc, -1);
    end else begin
      check({tag, ".busy_first"}, int'(busy_first), 1);
      if (kind == 1) check({tag, ".done_cyc"}, done_cyc, exp_cyc);
      else           check({tag, ".done_seen"}, int'(done_cyc > 0), 1);
      check({tag, ".nx"}, nx, exp_nx);
      check({tag, ".ny"}, ny, exp_ny);
      check({tag, ".dir"}, dir_err, 0);
      check({tag, ".width"}, bad_w, 0);
      if (diag) check({tag, ".coincident"}, noncoinc, 0);
      check({tag, ".dropped"}, ndrop, (drop_at > 0) ? 1 : 0);
    end
    check({tag, ".fault"}, int'(bus.fault), int'(fault_m));
    check({tag, ".magnet"}, int'(bus.magnet), int'(mag_m));
    bus.limit_x_n = 1'b1;
    bus.limit_y_n = 1'b1;
  endtask

  task automatic magnet_cycle(input logic on, input logic off, input string tag);
    @(negedge clk);
    bus.magnet_on = on; bus.magnet_off = off;
    @(negedge clk);
    bus.magnet_on = 1'b0; bus.magnet_off = 1'b0;
    mag_m = off ? 1'b0 : (on ? 1'b1 : mag_m);
    check(tag, int'(bus.magnet), int'(mag_m));
  endtask

  function automatic int outs_vec();
    return int'({bus.step_x, bus.step_y, bus.dir_x, bus.dir_y, bus.magnet,
                 bus.busy, bus.move_done, bus.cmd_dropped, bus.fault});
  endfunction

  initial begin
    int busy_cnt;
    logic [7:0] d;
    clear_cmds();
    bus.magnet_on = 1'b0; bus.magnet_off = 1'b0;
    bus.limit_x_n = 1'b1; bus.limit_y_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.outs", outs_vec(), 0);
    rst_n = 1'b1;

    exec(8'h02, 1'b0, 1'b0, -1, -1, 1'b0, "ne");
    exec(8'h00, 1'b0, 1'b1, -1, -1, 1'b0, "offset");
    magnet_cycle(1'b1, 1'b0, "mag.on");
    exec(8'h00, 1'b1, 1'b0, 3, 0, 1'b0, "home_lim");
    exec(8'h00, 1'b1, 1'b0, -1, -1, 1'b0, "home_timeout");
    exec(8'h00, 1'b1, 1'b0, 0, 0, 1'b0, "home_clear");
    exec(8'h01 << $urandom_range(0, 7), 1'b0, 1'b0, -1, -1, 1'b1, "drop");
    exec(8'h01, 1'b1, 1'b0, 0, 0, 1'b0, "dir_and_reset");
    exec(8'h03, 1'b0, 1'b0, -1, -1, 1'b0, "invalid_dir");
    magnet_cycle(1'b1, 1'b1, "mag.both");

    for (int i = 0; i < 12; i++) magnet_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "mag.rand");

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 5) == 0) exec(8'h00, 1'b0, 1'b1, -1, -1, 1'($urandom_range(0, 1)), "rand_off");
      else begin
        d = 8'h01 << $urandom_range(0, 7);
        exec(d, 1'b0, 1'($urandom_range(0, 3) == 0), -1, -1, 1'($urandom_range(0, 1)), "rand_move");
      end
    end

    magnet_cycle(1'b1, 1'b0, "mag.pre_abort");
    @(negedge clk);
    bus.direction = 8'h04;
    @(negedge clk);
    clear_cmds();
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort.outs", outs_vec(), 0);
    mag_m = 1'b0; fault_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy || bus.step_x) busy_cnt++;
    end
    check("abort.no_resume", busy_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
